// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin scheduler for the shared 16-bit ALU.
// Operands are registered toward the ALU, the result and flags are captured
// one cycle after issue and handed back over a per-requester valid/ready
// response channel. A saturating operand-bus toggle counter feeds power
// estimation.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int ACT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_z,
    output logic [4:0]       rsp0_flags,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_z,
    output logic [4:0]       rsp1_flags,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_s,
    input  logic             alu_cr,
    input  logic             alu_ze,
    input  logic             alu_p,
    input  logic             alu_o,

    input  logic             clr_count,
    output logic [ACT_W-1:0] toggle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Increment width holds up to 2*WIDTH toggles; the sum gets one spare
    // bit above the wider operand so saturation can be detected.
    localparam int INC_W = $clog2(2 * WIDTH + 1);
    localparam int SUM_W = ((ACT_W > INC_W) ? ACT_W : INC_W) + 1;

    state_t           state;
    state_t           next_state;

    logic             grant_sel;
    logic             any_req;
    logic             accept;
    logic             rsp_done;
    logic             gnt;
    logic             last_grant;

    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] result_z;
    logic [4:0]       result_flags;

    logic [INC_W-1:0] inc;
    logic [ACT_W-1:0] base_count;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sat_max;
    logic [ACT_W-1:0] next_count;

    function automatic logic [INC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{(INC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not
    // win last time.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign any_req  = req0_valid | req1_valid;
    assign accept   = (state == IDLE) && any_req;
    assign rsp_done = gnt ? rsp1_ready : rsp0_ready;
    assign sel_x    = grant_sel ? req1_x : req0_x;
    assign sel_y    = grant_sel ? req1_y : req0_y;

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept -> one settle cycle -> hold response until consumed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: handshakes only in the state that owns them.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant_sel;
                req1_ready = req1_valid && grant_sel;
            end
            RESP: begin
                rsp0_valid = !gnt;
                rsp1_valid = gnt;
            end
            default: begin
                req0_ready = 1'b0;
            end
        endcase
    end

    // Operand registers and grant owner load only on accept so an idle ALU
    // sees a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x <= '0;
            alu_y <= '0;
            gnt   <= 1'b0;
        end else if (accept) begin
            alu_x <= sel_x;
            alu_y <= sel_y;
            gnt   <= grant_sel;
        end
    end

    // Round-robin history moves only when a response is consumed; reset
    // value 1 lets req0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if ((state == RESP) && rsp_done) begin
            last_grant <= gnt;
        end
    end

    // Capture the ALU result at the end of the settle cycle; it stays put
    // through any response backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_z     <= '0;
            result_flags <= '0;
        end else if (state == ISSUE) begin
            result_z     <= alu_z;
            result_flags <= {alu_o, alu_p, alu_ze, alu_cr, alu_s};
        end
    end

    assign rsp0_z     = result_z;
    assign rsp1_z     = result_z;
    assign rsp0_flags = result_flags;
    assign rsp1_flags = result_flags;

    // Toggle increment and saturating sum; a clear in the accept cycle
    // restarts the total from this accept's increment alone.
    always_comb begin
        inc        = popcount(alu_x ^ sel_x) + popcount(alu_y ^ sel_y);
        base_count = clr_count ? '0 : toggle_count;
        sum        = {{(SUM_W-ACT_W){1'b0}}, base_count} + {{(SUM_W-INC_W){1'b0}}, inc};
        sat_max    = {{(SUM_W-ACT_W){1'b0}}, {ACT_W{1'b1}}};
        next_count = (sum > sat_max) ? {ACT_W{1'b1}} : sum[ACT_W-1:0];
    end

    // Toggle counter updates on the same edge that loads the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_count <= '0;
        end else if (accept) begin
            toggle_count <= next_count;
        end else if (clr_count) begin
            toggle_count <= '0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with hand-computed expectations for the
// ALU arbiter. An adder-style ALU (Z=X+Y, carry, sign, zero, even parity,
// signed overflow) is modelled next to each instance.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_z, rsp1_z;
    logic [4:0]  rsp0_flags, rsp1_flags;
    logic [15:0] alu_x, alu_y, alu_z;
    logic        alu_s, alu_cr, alu_ze, alu_p, alu_o;
    logic        clr_count;
    logic [23:0] toggle_count;

    logic        s_req0_valid, s_req0_ready, s_req1_ready;
    logic [15:0] s_req0_x, s_req0_y;
    logic        s_rsp0_valid, s_rsp1_valid, s_rsp0_ready;
    logic [15:0] s_rsp0_z, s_rsp1_z;
    logic [4:0]  s_rsp0_flags, s_rsp1_flags;
    logic [15:0] s_alu_x, s_alu_y, s_alu_z;
    logic        s_alu_s, s_alu_cr, s_alu_ze, s_alu_p, s_alu_o;
    logic [3:0]  s_toggle_count;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    // Adder ALU model for the main instance.
    always_comb begin
        {alu_cr, alu_z} = {1'b0, alu_x} + {1'b0, alu_y};
        alu_s  = alu_z[15];
        alu_ze = (alu_z == 16'h0000);
        alu_p  = ~^alu_z;
        alu_o  = (alu_x[15] == alu_y[15]) && (alu_z[15] != alu_x[15]);
    end

    // Same ALU model for the narrow-counter instance.
    always_comb begin
        {s_alu_cr, s_alu_z} = {1'b0, s_alu_x} + {1'b0, s_alu_y};
        s_alu_s  = s_alu_z[15];
        s_alu_ze = (s_alu_z == 16'h0000);
        s_alu_p  = ~^s_alu_z;
        s_alu_o  = (s_alu_x[15] == s_alu_y[15]) && (s_alu_z[15] != s_alu_x[15]);
    end

    alu_arbiter #(.WIDTH(16), .ACT_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_flags(rsp1_flags),
        .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .alu_s(alu_s), .alu_cr(alu_cr), .alu_ze(alu_ze), .alu_p(alu_p), .alu_o(alu_o),
        .clr_count(clr_count), .toggle_count(toggle_count)
    );

    alu_arbiter #(.WIDTH(16), .ACT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_x(s_req0_x), .req0_y(s_req0_y),
        .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_x(16'h0000), .req1_y(16'h0000),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(s_rsp0_ready), .rsp0_z(s_rsp0_z), .rsp0_flags(s_rsp0_flags),
        .rsp1_valid(s_rsp1_valid), .rsp1_ready(1'b0), .rsp1_z(s_rsp1_z), .rsp1_flags(s_rsp1_flags),
        .alu_x(s_alu_x), .alu_y(s_alu_y), .alu_z(s_alu_z),
        .alu_s(s_alu_s), .alu_cr(s_alu_cr), .alu_ze(s_alu_ze), .alu_p(s_alu_p), .alu_o(s_alu_o),
        .clr_count(1'b0), .toggle_count(s_toggle_count)
    );

    // Advance one clock and land 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] x0, input logic [15:0] y0,
                                 input logic v1, input logic [15:0] x1, input logic [15:0] y1);
        req0_valid = v0;
        req0_x     = x0;
        req0_y     = y0;
        req1_valid = v1;
        req1_x     = x1;
        req1_y     = y1;
    endtask

    // Full req0 transaction on the main instance with the response consumed immediately.
    task automatic runTxn0(input logic [15:0] x, input logic [15:0] y, input logic clr);
        applyStimulus(1'b1, x, y, 1'b0, 16'h0, 16'h0);
        clr_count = clr;
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        clr_count = 1'b0;
        tick();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    // Full transaction on the narrow-counter instance.
    task automatic runSat(input logic [15:0] x, input logic [15:0] y);
        s_req0_valid = 1'b1;
        s_req0_x     = x;
        s_req0_y     = y;
        tick();
        s_req0_valid = 1'b0;
        tick();
        s_rsp0_ready = 1'b1;
        tick();
        s_rsp0_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        rsp0_ready   = 1'b0;
        rsp1_ready   = 1'b0;
        clr_count    = 1'b0;
        s_req0_valid = 1'b0;
        s_req0_x     = 16'h0;
        s_req0_y     = 16'h0;
        s_rsp0_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("reset_alu_x", {16'h0, alu_x}, 32'h0);
        checkOutput("reset_alu_y", {16'h0, alu_y}, 32'h0);
        checkOutput("reset_toggle", {8'h0, toggle_count}, 32'h0);
        checkOutput("reset_rsp_valid", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);

        // Single request after reset
        applyStimulus(1'b1, 16'h4F80, 16'h1234, 1'b0, 16'h0, 16'h0);
        #1;
        checkOutput("single_ready", {30'h0, req1_ready, req0_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        checkOutput("single_alu_x", {16'h0, alu_x}, 32'h4F80);
        checkOutput("single_toggle", {8'h0, toggle_count}, 32'd11);
        checkOutput("single_issue_novalid", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
        checkOutput("single_issue_noready", {30'h0, req1_ready, req0_ready}, 32'h0);
        tick();
        checkOutput("single_rsp_valid", {30'h0, rsp1_valid, rsp0_valid}, 32'h1);
        checkOutput("single_z", {16'h0, rsp0_z}, 32'h61B4);
        checkOutput("single_flags", {27'h0, rsp0_flags}, 32'h00);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Tie: last_grant is now 0, so req1 wins
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h4E87, 16'h8000);
        #1;
        checkOutput("tie1_ready", {30'h0, req1_ready, req0_ready}, 32'h2);
        tick();
        checkOutput("tie1_toggle", {8'h0, toggle_count}, 32'd21);
        checkOutput("tie1_alu_y", {16'h0, alu_y}, 32'h8000);
        tick();
        checkOutput("tie1_rsp_valid", {30'h0, rsp1_valid, rsp0_valid}, 32'h2);
        checkOutput("tie1_z", {16'h0, rsp1_z}, 32'hCE87);
        checkOutput("tie1_flags", {27'h0, rsp1_flags}, 32'h01);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // Tie again: req0 now wins
        #1;
        checkOutput("tie2_ready", {30'h0, req1_ready, req0_ready}, 32'h1);
        tick();
        req0_valid = 1'b0;
        checkOutput("tie2_toggle", {8'h0, toggle_count}, 32'd31);
        tick();

        // Backpressure on rsp0 while req1 keeps waiting
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", {30'h0, rsp1_valid, rsp0_valid}, 32'h1);
            checkOutput("bp_z", {16'h0, rsp0_z}, 32'h0000);
            checkOutput("bp_flags", {27'h0, rsp0_flags}, 32'h0E);
            checkOutput("bp_req1_ready", {31'h0, req1_ready}, 32'h0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        checkOutput("bp_resume_ready", {30'h0, req1_ready, req0_ready}, 32'h2);
        tick();
        req1_valid = 1'b0;
        checkOutput("bp_resume_toggle", {8'h0, toggle_count}, 32'd41);
        tick();
        checkOutput("bp_resume_rsp1", {30'h0, rsp1_valid, rsp0_valid}, 32'h2);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // Clear without accept
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        checkOutput("clr_alone", {8'h0, toggle_count}, 32'h0);

        // Clear colliding with an accept, previous operands zero, counter nonzero
        runTxn0(16'hFFFF, 16'h0000, 1'b0);
        runTxn0(16'h0000, 16'h0000, 1'b0);
        checkOutput("clr_pre_nonzero", {31'h0, (toggle_count != 24'h0)}, 32'h1);
        runTxn0(16'h0001, 16'h0000, 1'b1);
        checkOutput("clr_collision", {8'h0, toggle_count}, 32'd1);

        // Reset during ISSUE: last_grant is 0, so req1 takes this tie
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3333, 16'h4444);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        checkOutput("midop_loaded", {16'h0, alu_x}, 32'h3333);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_alu_x", {16'h0, alu_x}, 32'h0);
        checkOutput("midop_alu_y", {16'h0, alu_y}, 32'h0);
        checkOutput("midop_toggle", {8'h0, toggle_count}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("midop_no_rsp", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0);
        #1;
        checkOutput("midop_tie_req0", {30'h0, req1_ready, req0_ready}, 32'h1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);

        // Saturation on the 4-bit counter instance (reset above applied to it too)
        runSat(16'hFFFF, 16'h0000);
        checkOutput("sat_first", {28'h0, s_toggle_count}, 32'd15);
        checkOutput("sat_z", {16'h0, s_rsp0_z}, 32'hFFFF);
        runSat(16'h0000, 16'hFFFF);
        checkOutput("sat_second", {28'h0, s_toggle_count}, 32'd15);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester scheduler for the shared 16-bit ALU (outputs Z plus flags S, Cr, Ze, P, O). It arbitrates round-robin between two operand requesters and drives the ALU operand inputs from registers. It captures the ALU result and flags one cycle after issue and returns them over a per-requester valid/ready response channel. It also accumulates an operand-bus toggle count that feeds the power-estimation path.

## Interface
- WIDTH, 16, operand/result width
- ACT_W, 24, toggle counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_ready / req1_ready  out  1  arbiter accepts the pair this cycle
- req0_x, req0_y / req1_x, req1_y  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available to requester
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- rsp0_z / rsp1_z  out  WIDTH  registered ALU result
- rsp0_flags / rsp1_flags  out  5  registered {O,P,Ze,Cr,S}, bit4..bit0
- alu_x, alu_y  out  WIDTH  registered operands to the ALU
- alu_z  in  WIDTH  ALU result (combinational from alu_x/alu_y)
- alu_s, alu_cr, alu_ze, alu_p, alu_o  in  1  ALU flags
- clr_count  in  1  synchronous clear of toggle_count
- toggle_count  out  ACT_W  saturating operand-bit toggle total

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready = (state==IDLE) && granted N. It is combinational from the valids and last_grant.
- Accept happens on valid&&ready:
  - alu_x/alu_y ← reqN_x/reqN_y
  - gnt ← N
  - → ISSUE
- ISSUE (one cycle, ALU settle):
  - At end of cycle, the result register captures alu_z and {alu_o,alu_p,alu_ze,alu_cr,alu_s}.
  - → RESP
- RESP:
  - rsp{gnt}_valid = 1; the other rsp_valid = 0.
  - On rsp{gnt}_ready: last_grant ← gnt, → IDLE.
  - No req_ready is asserted in ISSUE or RESP.
- rsp0_z/rsp1_z and the flag outputs both present the single shared result register. Only the matching rspN_valid qualifies them.
- alu_x/alu_y change only on accept and hold otherwise, so an idle ALU does not toggle.
- Toggle count:
  - On accept, add popcount(alu_x ^ new_x) + popcount(alu_y ^ new_y). The increment is at most 2·WIDTH.
  - The sum saturates at 2^ACT_W−1 and never wraps.
  - clr_count without accept → 0.
  - clr_count with accept in the same cycle → the counter equals that accept's increment only.
- Reset values: state IDLE; last_grant = 1, so req0 wins the first tie; alu_x = alu_y = 0; result register 0; all rsp_valid 0; toggle_count 0.
- Reset mid-operation: the transaction in flight is dropped, no response is issued, and all of the reset values above apply immediately.

## Timing
- An accept at edge t puts alu_x/alu_y valid after t. The result is captured at t+1 and rspN_valid is high after t+1.
- Minimum interval between accepts is 3 cycles (IDLE→ISSUE→RESP→IDLE) when rsp_ready is held high.
- rspN_valid stays high, with z and flags stable, until rspN_ready is seen. Backpressure stalls arbitration.
- reqN_x/reqN_y are sampled only at the accept edge and may change afterwards.
- toggle_count updates at the accept edge, i.e. the same edge that loads alu_x/alu_y.

## Test plan
- Single request after reset:
  - Stimulus: req0 X=4F80, Y=1234.
  - Response: req0_ready in the same cycle; rsp0_valid 2 cycles later; rsp0_z/rsp0_flags equal the ALU model for those operands; toggle_count=11.
- Back-to-back and tie-break:
  - Stimulus: after the above, req0 and req1 both held valid; req1 carries X=4E87, Y=8000.
  - Response: req1 is granted first because last_grant=0; toggle_count=21; req0 is then granted next.
- Backpressure:
  - Stimulus: rsp0_ready held low for 5 cycles.
  - Response: rsp0_valid stays high with z and flags unchanged; req1_ready stays 0 throughout; normal progress resumes one cycle after ready rises.
- Saturation:
  - Stimulus: ACT_W=4; accept X=FFFF, Y=0000 from reset, then X=0000, Y=FFFF.
  - Response: toggle_count reads 15 after the first accept and stays 15.
- Clear collision:
  - Stimulus: clr_count coincident with an accept of X=0001, Y=0000 (previous operands 0).
  - Response: toggle_count=1.
- Reset mid-op:
  - Stimulus: rst_n low during ISSUE.
  - Response: no rsp_valid ever pulses; alu_x/alu_y = 0; the next tie grants req0.
